// File: rtl/vga_tile_pkg.sv
// Shared constants and types for the VGA tile-fetch stage.
//   TILE_W / TILE_SH : tile edge in pixels and its log2
//   RGB_W            : pixel colour width (4:4:4)
//   CODE_W           : board-cell tile code width
//   TILE_EMPTY       : code of an empty cell
//   map_state_e      : board-map FSM states (CLEAR walks the map, RUN serves writes)
package vga_tile_pkg;

  localparam int TILE_W  = 16;
  localparam int TILE_SH = 4;
  localparam int RGB_W   = 12;
  localparam int CODE_W  = 4;

  localparam logic [CODE_W-1:0] TILE_EMPTY = 4'd0;

  typedef enum logic {
    MAP_CLEAR = 1'b0,
    MAP_RUN   = 1'b1
  } map_state_e;

endpackage

// File: rtl/vga_tile_fetch_if.sv
// Read port of the 4096x12 tile RAM.
//   ren   : read enable, qualifies raddr in the same cycle
//   raddr : {tile[3:0], ty[3:0], tx[3:0]}
//   rdata : pixel colour
// Handshake: no backpressure. When ren is high in cycle n, the RAM returns the
// word at raddr on rdata in cycle n+1. raddr is a don't-care while ren is low.
// master = fetch stage, slave = tile RAM.
interface vga_tile_fetch_if;
  import vga_tile_pkg::*;

  logic             ren;
  logic [11:0]      raddr;
  logic [RGB_W-1:0] rdata;

  modport master (output ren, output raddr, input rdata);
  modport slave  (input ren, input raddr, output rdata);

endinterface

// File: rtl/vga_tile_map.sv
// Board tile map: ROWS*COLS cells of CODE_W bits, one write port and one
// registered read port.
//   clk, rst          : clock, synchronous active-high reset
//   wen_i/wrow_i/wcol_i/wdata_i : cell write (ignored while busy or out of range)
//   rrow_i/rcol_i     : cell read address, result on rdata_o one clk later
//   rdata_o           : registered tile code (TILE_EMPTY while clearing/out of range)
//   busy_o            : high while the map is being cleared
//   state_o           : FSM state for observation
// After reset the FSM walks every cell writing TILE_EMPTY, one per clk.
module vga_tile_map
  import vga_tile_pkg::*;
#(
  parameter int ROWS = 20,
  parameter int COLS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen_i,
  input  logic [4:0]        wrow_i,
  input  logic [3:0]        wcol_i,
  input  logic [CODE_W-1:0] wdata_i,
  input  logic [4:0]        rrow_i,
  input  logic [3:0]        rcol_i,
  output logic [CODE_W-1:0] rdata_o,
  output logic              busy_o,
  output map_state_e        state_o
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = $clog2(N);

  logic [CODE_W-1:0] mem [N];

  map_state_e        state_q, state_d;
  logic [IDX_W-1:0]  clr_q, clr_d;
  logic              we;
  logic [IDX_W-1:0]  waddr;
  logic [CODE_W-1:0] wdata;
  logic [8:0]        wlin, rlin;
  logic              w_ok, r_ok;
  logic [CODE_W-1:0] rd_q;

  // Linear cell index row*COLS+col; range checks guard the aliasing that an
  // out-of-range column would otherwise cause into the next row.
  assign wlin = 9'(wrow_i) * 9'(COLS) + 9'(wcol_i);
  assign rlin = 9'(rrow_i) * 9'(COLS) + 9'(rcol_i);
  assign w_ok = ({1'b0, wrow_i} < 6'(ROWS)) && ({1'b0, wcol_i} < 5'(COLS));
  assign r_ok = ({1'b0, rrow_i} < 6'(ROWS)) && ({1'b0, rcol_i} < 5'(COLS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MAP_CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    we      = 1'b0;
    waddr   = IDX_W'(wlin);
    wdata   = wdata_i;
    case (state_q)
      MAP_CLEAR: begin
        we    = 1'b1;
        waddr = clr_q;
        wdata = TILE_EMPTY;
        if (clr_q == IDX_W'(N - 1)) begin
          state_d = MAP_RUN;
          clr_d   = '0;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      MAP_RUN: we = wen_i && w_ok;
      default: state_d = MAP_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Non-blocking write means a same-cycle read of the written cell returns
  // the old contents. The board reads as empty until the clear completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= TILE_EMPTY;
    end else if (state_q == MAP_CLEAR || !r_ok) begin
      rd_q <= TILE_EMPTY;
    end else begin
      rd_q <= mem[IDX_W'(rlin)];
    end
  end

  assign rdata_o = rd_q;
  assign busy_o  = (state_q == MAP_CLEAR);
  assign state_o = state_q;

endmodule

// File: rtl/vga_tile_fetch.sv
// Pixel-stream stage in front of the tile RAM: decodes raster position against
// the Tetris board, looks up the tile code, issues the RAM read and merges the
// returned pixel with the background into a 3-clk delayed RGB stream.
//   clk, rst                 : pixel clock, synchronous active-high reset
//   pix_x/pix_y/pix_de/pix_hs/pix_vs : raster input from VGA timing
//   map_wen/map_wrow/map_wcol/map_wdata : board-cell write port
//   map_busy                 : map clear in progress, writes ignored
//   ram                      : tile RAM read port (master side)
//   rgb_out/de_out/hs_out/vs_out : aligned output stream
//   map_state_dbg            : board-map FSM state
// Pipeline: S1 decode + map read, S2 RAM address/enable, S3 RAM data + mux.
// Build option: define VGA_TILE_BORDER_EN to draw a 4-px frame around the board.
module vga_tile_fetch
  import vga_tile_pkg::*;
#(
  parameter int               BOARD_X0   = 240,
  parameter int               BOARD_Y0   = 80,
  parameter int               BOARD_COLS = 10,
  parameter int               BOARD_ROWS = 20,
`ifdef VGA_TILE_BORDER_EN
  parameter logic [RGB_W-1:0] BORDER_RGB = 12'hFFF,
`endif
  parameter logic [RGB_W-1:0] BG_RGB     = 12'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              pix_de,
  input  logic              pix_hs,
  input  logic              pix_vs,
  input  logic              map_wen,
  input  logic [4:0]        map_wrow,
  input  logic [3:0]        map_wcol,
  input  logic [CODE_W-1:0] map_wdata,
  output logic              map_busy,
  vga_tile_fetch_if.master  ram,
  output logic [RGB_W-1:0]  rgb_out,
  output logic              de_out,
  output logic              hs_out,
  output logic              vs_out,
  output map_state_e        map_state_dbg
);

  localparam logic [9:0] X_LO = 10'(BOARD_X0);
  localparam logic [9:0] X_HI = 10'(BOARD_X0 + TILE_W * BOARD_COLS);
  localparam logic [9:0] Y_LO = 10'(BOARD_Y0);
  localparam logic [9:0] Y_HI = 10'(BOARD_Y0 + TILE_W * BOARD_ROWS);

  // S1 decode. Offsets only matter when in_board holds, so the narrow
  // subtraction never has to represent a negative value.
  logic       in_board;
  logic [7:0] dx;
  logic [8:0] dy;

  assign in_board = pix_de && (pix_x >= X_LO) && (pix_x < X_HI) &&
                    (pix_y >= Y_LO) && (pix_y < Y_HI);
  assign dx = pix_x[7:0] - X_LO[7:0];
  assign dy = pix_y[8:0] - Y_LO[8:0];

  logic [CODE_W-1:0] tile;

  vga_tile_map #(
    .ROWS (BOARD_ROWS),
    .COLS (BOARD_COLS)
  ) u_map (
    .clk     (clk),
    .rst     (rst),
    .wen_i   (map_wen),
    .wrow_i  (map_wrow),
    .wcol_i  (map_wcol),
    .wdata_i (map_wdata),
    .rrow_i  (dy[8:4]),
    .rcol_i  (dx[7:4]),
    .rdata_o (tile),
    .busy_o  (map_busy),
    .state_o (map_state_dbg)
  );

  logic       s1_de_q, s1_hs_q, s1_vs_q, s1_in_q;
  logic [3:0] s1_tx_q, s1_ty_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_de_q <= 1'b0;
      s1_hs_q <= 1'b1;
      s1_vs_q <= 1'b1;
      s1_in_q <= 1'b0;
      s1_tx_q <= '0;
      s1_ty_q <= '0;
    end else begin
      s1_de_q <= pix_de;
      s1_hs_q <= pix_hs;
      s1_vs_q <= pix_vs;
      s1_in_q <= in_board;
      s1_tx_q <= dx[3:0];
      s1_ty_q <= dy[3:0];
    end
  end

  // S2: the map read lands together with the S1 registers, so the RAM port
  // is driven straight from them; the RAM's own register forms the S2/S3 step.
  assign ram.ren   = s1_in_q && (tile != TILE_EMPTY);
  assign ram.raddr = {tile, s1_ty_q, s1_tx_q};

  logic s2_de_q, s2_hs_q, s2_vs_q, s2_hit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_de_q  <= 1'b0;
      s2_hs_q  <= 1'b1;
      s2_vs_q  <= 1'b1;
      s2_hit_q <= 1'b0;
    end else begin
      s2_de_q  <= s1_de_q;
      s2_hs_q  <= s1_hs_q;
      s2_vs_q  <= s1_vs_q;
      s2_hit_q <= ram.ren;
    end
  end

`ifdef VGA_TILE_BORDER_EN
  localparam logic [9:0] X_BLO = 10'(BOARD_X0 - 4);
  localparam logic [9:0] X_BHI = 10'(BOARD_X0 + TILE_W * BOARD_COLS + 4);
  localparam logic [9:0] Y_BLO = 10'(BOARD_Y0 - 4);
  localparam logic [9:0] Y_BHI = 10'(BOARD_Y0 + TILE_W * BOARD_ROWS + 4);

  // Frame = enlarged rectangle minus the board itself (corners included).
  logic in_frame;
  logic s1_frame_q, s2_frame_q;

  assign in_frame = pix_de && !in_board && (pix_x >= X_BLO) && (pix_x < X_BHI) &&
                    (pix_y >= Y_BLO) && (pix_y < Y_BHI);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_frame_q <= 1'b0;
      s2_frame_q <= 1'b0;
    end else begin
      s1_frame_q <= in_frame;
      s2_frame_q <= s1_frame_q;
    end
  end
`endif

  logic [RGB_W-1:0] rgb_q;
  logic             de_q, hs_q, vs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= '0;
      de_q  <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      de_q <= s2_de_q;
      hs_q <= s2_hs_q;
      vs_q <= s2_vs_q;
      if (!s2_de_q)      rgb_q <= '0;
      else if (s2_hit_q) rgb_q <= ram.rdata;
`ifdef VGA_TILE_BORDER_EN
      else if (s2_frame_q) rgb_q <= BORDER_RGB;
`endif
      else               rgb_q <= BG_RGB;
    end
  end

  assign rgb_out = rgb_q;
  assign de_out  = de_q;
  assign hs_out  = hs_q;
  assign vs_out  = vs_q;

endmodule
